// File: rtl/gun_pos_arbiter.sv
// Light-gun position generator for the williams2 board.
// The joystick and a relative pointer (mouse deltas) share one 6-bit (h, v)
// position. Every update is made on the rising edge of the 4 ms tick.
// The joystick has accelerating auto-repeat and always wins arbitration.
// The mouse path keeps a sub-step remainder in signed accumulators.
module gun_pos_arbiter #(
   parameter int DIV_START   = 3,
   parameter int DIV_MIN     = 0,
   parameter int IDLE_TICKS  = 250,
   parameter int MOUSE_SHIFT = 2,
   parameter int CENTER      = 32
) (
   input  logic       clock_12,
   input  logic       reset_n,
   input  logic       tick_4ms,
   input  logic       joy_left,
   input  logic       joy_right,
   input  logic       joy_up,
   input  logic       joy_down,
   input  logic       mouse_strobe,
   input  logic [8:0] mouse_dx,
   input  logic [8:0] mouse_dy,
   output logic [5:0] gun_h,
   output logic [5:0] gun_v,
   output logic [1:0] owner
);

   localparam int DW = (DIV_START < 1) ? 1 : $clog2(DIV_START + 1);
   localparam int IW = $clog2(IDLE_TICKS + 1);
   localparam logic [DW-1:0] DIV_START_C = DW'(DIV_START);
   localparam logic [DW-1:0] DIV_MIN_C   = DW'(DIV_MIN);
   localparam logic [DW-1:0] ONE_C       = DW'(1'b1);
   localparam logic [IW-1:0] IDLE_LAST_C = IW'(IDLE_TICKS - 1);
   localparam logic [5:0]    CENTER_C    = 6'(CENTER);

   typedef enum logic {AX_IDLE = 1'b0, AX_REPEAT = 1'b1} axis_state_e;

   // Repeat period shrinks by one per step, never below the minimum.
   function automatic logic [DW-1:0] dec_period(input logic [DW-1:0] p);
      if (p > DIV_MIN_C) return p - ONE_C;
      else               return DIV_MIN_C;
   endfunction

   // Accumulator add that saturates at +/-1023 instead of wrapping.
   function automatic logic signed [10:0] sat_add(input logic signed [10:0] acc,
                                                  input logic signed [11:0] delta);
      logic signed [12:0] sum;
      sum = $signed({{2{acc[10]}}, acc}) + $signed({delta[11], delta});
      if (sum > 13'sd1023)       return 11'sd1023;
      else if (sum < -13'sd1023) return -11'sd1023;
      else                       return sum[10:0];
   endfunction

   // Whole gun steps held in an accumulator, truncated toward zero.
   function automatic logic signed [10:0] trunc_step(input logic signed [10:0] acc);
      logic [10:0] mag;
      logic [10:0] mag_sh;
      mag    = acc[10] ? 11'(-acc) : acc;
      mag_sh = mag >> MOUSE_SHIFT;
      if (acc[10]) return -$signed(mag_sh);
      else         return $signed(mag_sh);
   endfunction

   // Position plus signed step, held at the screen edges (no wrap).
   function automatic logic [5:0] clamp_pos(input logic [5:0] pos,
                                            input logic signed [10:0] step);
      logic signed [11:0] sum;
      sum = $signed({6'd0, pos}) + $signed({step[10], step});
      if (sum < 12'sd0)       return 6'd0;
      else if (sum > 12'sd63) return 6'd63;
      else                    return sum[5:0];
   endfunction

   logic              tick_prev_q;   // previous tick_4ms level
   logic              tick_s;
   logic [1:0]        dir_act_s;
   logic [1:0]        dir_inc_s;
   logic              joy_act_s;
   logic              mouse_act_s;
   axis_state_e       ax_state_q [2];
   axis_state_e       ax_state_d [2];
   logic [DW-1:0]     div_q      [2];
   logic [DW-1:0]     div_d      [2];
   logic [DW-1:0]     period_q   [2];
   logic [DW-1:0]     period_d   [2];
   logic signed [10:0] jstep_s   [2];
   logic signed [10:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic signed [10:0] step_x_s, step_y_s, rem_x_s, rem_y_s, base_x_s, base_y_s;
   logic signed [11:0] dx_ext_s, ndy_ext_s;
   logic [5:0]         gun_h_q, gun_h_d, gun_v_q, gun_v_d;
   logic [1:0]         owner_q, owner_d;
   logic [IW-1:0]      idle_q, idle_d;

   // Edge detect of the tick and decode of the joystick directions.
   always_comb begin
      tick_s       = tick_4ms & ~tick_prev_q;
      dir_act_s[0] = joy_left ^ joy_right;
      dir_inc_s[0] = joy_right;
      dir_act_s[1] = joy_up ^ joy_down;
      dir_inc_s[1] = joy_down;
      joy_act_s    = dir_act_s[0] | dir_act_s[1];
   end

   // Per-axis auto-repeat FSM: next state, divider, period and step.
   always_comb begin
      for (int a = 0; a < 2; a++) begin
         ax_state_d[a] = ax_state_q[a];
         div_d[a]      = div_q[a];
         period_d[a]   = period_q[a];
         jstep_s[a]    = 11'sd0;
         if (tick_s) begin
            case (ax_state_q[a])
               AX_IDLE: begin
                  if (dir_act_s[a]) begin
                     ax_state_d[a] = AX_REPEAT;
                     jstep_s[a]    = dir_inc_s[a] ? 11'sd1 : -11'sd1;
                     div_d[a]      = period_q[a];
                     period_d[a]   = dec_period(period_q[a]);
                  end else begin
                     div_d[a]    = {DW{1'b0}};
                     period_d[a] = DIV_START_C;
                  end
               end
               AX_REPEAT: begin
                  if (!dir_act_s[a]) begin
                     ax_state_d[a] = AX_IDLE;
                     div_d[a]      = {DW{1'b0}};
                     period_d[a]   = DIV_START_C;
                  end else if (div_q[a] == {DW{1'b0}}) begin
                     jstep_s[a]  = dir_inc_s[a] ? 11'sd1 : -11'sd1;
                     div_d[a]    = period_q[a];
                     period_d[a] = dec_period(period_q[a]);
                  end else begin
                     div_d[a] = div_q[a] - ONE_C;
                  end
               end
               default: begin
                  ax_state_d[a] = AX_IDLE;
                  div_d[a]      = {DW{1'b0}};
                  period_d[a]   = DIV_START_C;
               end
            endcase
         end else begin
            jstep_s[a] = 11'sd0;
         end
      end
   end

   // Mouse accumulators: step extraction on tick, then the strobe is added.
   always_comb begin
      dx_ext_s    = $signed({{3{mouse_dx[8]}}, mouse_dx});
      ndy_ext_s   = 12'sd0 - $signed({{3{mouse_dy[8]}}, mouse_dy});
      step_x_s    = trunc_step(acc_x_q);
      step_y_s    = trunc_step(acc_y_q);
      rem_x_s     = acc_x_q - (step_x_s <<< MOUSE_SHIFT);
      rem_y_s     = acc_y_q - (step_y_s <<< MOUSE_SHIFT);
      mouse_act_s = (acc_x_q != 11'sd0) || (acc_y_q != 11'sd0);
      if (tick_s) begin
         base_x_s = rem_x_s;
         base_y_s = rem_y_s;
      end else begin
         base_x_s = acc_x_q;
         base_y_s = acc_y_q;
      end
      if (mouse_strobe) begin
         acc_x_d = sat_add(base_x_s, dx_ext_s);
         acc_y_d = sat_add(base_y_s, ndy_ext_s);
      end else begin
         acc_x_d = base_x_s;
         acc_y_d = base_y_s;
      end
      if (tick_s && joy_act_s) begin
         acc_x_d = 11'sd0;
         acc_y_d = 11'sd0;
      end else begin
         acc_x_d = acc_x_d;
         acc_y_d = acc_y_d;
      end
   end

   // Ownership arbitration, position update and idle release on tick.
   always_comb begin
      gun_h_d = gun_h_q;
      gun_v_d = gun_v_q;
      owner_d = owner_q;
      idle_d  = idle_q;
      if (tick_s) begin
         if (joy_act_s) begin
            owner_d = 2'd1;
            gun_h_d = clamp_pos(gun_h_q, jstep_s[0]);
            gun_v_d = clamp_pos(gun_v_q, jstep_s[1]);
            idle_d  = {IW{1'b0}};
         end else if (mouse_act_s) begin
            owner_d = 2'd2;
            gun_h_d = clamp_pos(gun_h_q, step_x_s);
            gun_v_d = clamp_pos(gun_v_q, step_y_s);
            idle_d  = {IW{1'b0}};
         end else if (owner_q == 2'd0) begin
            idle_d = {IW{1'b0}};
         end else if (idle_q == IDLE_LAST_C) begin
            owner_d = 2'd0;
            idle_d  = {IW{1'b0}};
         end else begin
            idle_d = idle_q + {{(IW-1){1'b0}}, 1'b1};
         end
      end else begin
         idle_d = idle_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock_12 or negedge reset_n) begin
      if (!reset_n) begin
         tick_prev_q <= 1'b0;
         for (int a = 0; a < 2; a++) begin
            ax_state_q[a] <= AX_IDLE;
            div_q[a]      <= {DW{1'b0}};
            period_q[a]   <= DIV_START_C;
         end
         acc_x_q <= 11'sd0;
         acc_y_q <= 11'sd0;
         gun_h_q <= CENTER_C;
         gun_v_q <= CENTER_C;
         owner_q <= 2'd0;
         idle_q  <= {IW{1'b0}};
      end else begin
         tick_prev_q <= tick_4ms;
         for (int a = 0; a < 2; a++) begin
            ax_state_q[a] <= ax_state_d[a];
            div_q[a]      <= div_d[a];
            period_q[a]   <= period_d[a];
         end
         acc_x_q <= acc_x_d;
         acc_y_q <= acc_y_d;
         gun_h_q <= gun_h_d;
         gun_v_q <= gun_v_d;
         owner_q <= owner_d;
         idle_q  <= idle_d;
      end
   end

   assign gun_h = gun_h_q;
   assign gun_v = gun_v_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_gun_pos_arbiter.sv
// Directed bench for gun_pos_arbiter: reset, joystick acceleration, edge
// clamping, mouse accumulation/saturation, priority, idle release and
// asynchronous reset in the middle of a repeat run.
module tb_gun_pos_arbiter;

   logic       clock_12;
   logic       reset_n;
   logic       tick_4ms;
   logic       joy_left, joy_right, joy_up, joy_down;
   logic       mouse_strobe;
   logic [8:0] mouse_dx, mouse_dy;
   logic [5:0] gun_h, gun_v;
   logic [1:0] owner;

   int checks   = 0;
   int failures = 0;
   int accel_exp [11] = '{33, 33, 33, 33, 34, 34, 34, 35, 35, 36, 37};
   logic saw_63;

   gun_pos_arbiter dut (
      .clock_12    (clock_12),
      .reset_n     (reset_n),
      .tick_4ms    (tick_4ms),
      .joy_left    (joy_left),
      .joy_right   (joy_right),
      .joy_up      (joy_up),
      .joy_down    (joy_down),
      .mouse_strobe(mouse_strobe),
      .mouse_dx    (mouse_dx),
      .mouse_dy    (mouse_dy),
      .gun_h       (gun_h),
      .gun_v       (gun_v),
      .owner       (owner)
   );

   initial begin
      clock_12 = 1'b0;
      forever #5 clock_12 = ~clock_12;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock_12);
      reset_n  = 1'b0;
      tick_4ms = 1'b0;
      @(negedge clock_12);
      @(negedge clock_12);
      reset_n = 1'b1;
      @(negedge clock_12);
   endtask

   task automatic tick();
      @(negedge clock_12);
      tick_4ms = 1'b1;
      @(negedge clock_12);
      tick_4ms = 1'b0;
      @(negedge clock_12);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic strobe(input int dx, input int dy);
      @(negedge clock_12);
      mouse_strobe = 1'b1;
      mouse_dx     = 9'(dx);
      mouse_dy     = 9'(dy);
      @(negedge clock_12);
      mouse_strobe = 1'b0;
      mouse_dx     = 9'd0;
      mouse_dy     = 9'd0;
   endtask

   task automatic tick_with_strobe(input int dx, input int dy);
      @(negedge clock_12);
      tick_4ms     = 1'b1;
      mouse_strobe = 1'b1;
      mouse_dx     = 9'(dx);
      mouse_dy     = 9'(dy);
      @(negedge clock_12);
      tick_4ms     = 1'b0;
      mouse_strobe = 1'b0;
      mouse_dx     = 9'd0;
      mouse_dy     = 9'd0;
      @(negedge clock_12);
   endtask

   initial begin
      reset_n = 1'b1; tick_4ms = 1'b0;
      joy_left = 1'b0; joy_right = 1'b0; joy_up = 1'b0; joy_down = 1'b0;
      mouse_strobe = 1'b0; mouse_dx = 9'd0; mouse_dy = 9'd0;

      // Reset state and long idle run.
      do_reset();
      chk("rst_h", gun_h, 32);
      chk("rst_v", gun_v, 32);
      chk("rst_owner", owner, 0);
      ticks(300);
      chk("idle300_h", gun_h, 32);
      chk("idle300_v", gun_v, 32);
      chk("idle300_owner", owner, 0);

      // Joystick acceleration.
      joy_right = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         chk($sformatf("accel_t%0d", i + 1), gun_h, accel_exp[i]);
      end
      chk("accel_owner", owner, 1);
      chk("accel_v", gun_v, 32);
      joy_right = 1'b0;
      tick();
      chk("release_h", gun_h, 37);
      joy_right = 1'b1;
      tick();
      chk("repress_t1", gun_h, 38);
      ticks(3);
      chk("repress_t4", gun_h, 38);
      tick();
      chk("repress_t5", gun_h, 39);

      // Left edge clamp.
      joy_right = 1'b0;
      joy_left  = 1'b1;
      saw_63    = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (gun_h == 6'd63) saw_63 = 1'b1;
      end
      chk("clamp_left_h", gun_h, 0);
      chk("clamp_no_wrap", saw_63, 0);
      joy_right = 1'b1;
      ticks(5);
      chk("both_pressed_h", gun_h, 0);
      chk("both_pressed_v", gun_v, 32);
      joy_left  = 1'b0;
      joy_right = 1'b0;

      // Mouse accumulation with remainder.
      do_reset();
      strobe(5, 0);
      tick();
      chk("mouse1_h", gun_h, 33);
      chk("mouse1_owner", owner, 2);
      strobe(3, 0);
      tick();
      chk("mouse2_h", gun_h, 34);
      strobe(-1, 0);
      tick();
      chk("mouse3_h", gun_h, 34);
      chk("mouse3_owner", owner, 2);
      strobe(0, 8);
      tick();
      chk("mouse4_v", gun_v, 30);
      chk("mouse4_h", gun_h, 34);

      // Accumulator saturation at +1023, then -1024 of deltas leaves -1.
      do_reset();
      for (int i = 0; i < 5; i++) strobe(255, 0);
      for (int i = 0; i < 4; i++) strobe(-256, 0);
      tick();
      chk("sat_h", gun_h, 32);
      chk("sat_owner", owner, 2);

      // Large mouse step clamps at the right edge.
      do_reset();
      for (int i = 0; i < 5; i++) strobe(255, 0);
      tick();
      chk("clamp_right_h", gun_h, 63);
      chk("clamp_right_v", gun_v, 32);

      // Strobe on the tick cycle counts toward the following tick.
      do_reset();
      strobe(4, 0);
      tick_with_strobe(8, 0);
      chk("coincide_t1_h", gun_h, 33);
      tick();
      chk("coincide_t2_h", gun_h, 35);

      // Joystick priority and idle release.
      do_reset();
      joy_down = 1'b1;
      tick_with_strobe(40, 0);
      chk("prio_v", gun_v, 33);
      chk("prio_h", gun_h, 32);
      chk("prio_owner", owner, 1);
      joy_down = 1'b0;
      tick();
      chk("prio_next_h", gun_h, 32);
      chk("prio_next_owner", owner, 1);
      ticks(248);
      chk("idle249_owner", owner, 1);
      tick();
      chk("idle250_owner", owner, 0);

      // Asynchronous reset during full-speed repeat.
      do_reset();
      joy_up = 1'b1;
      ticks(12);
      chk("up12_v", gun_v, 26);
      @(posedge clock_12);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_h", gun_h, 32);
      chk("async_rst_v", gun_v, 32);
      chk("async_rst_owner", owner, 0);
      @(negedge clock_12);
      @(negedge clock_12);
      reset_n = 1'b1;
      tick();
      chk("after_rst_t1", gun_v, 31);
      ticks(3);
      chk("after_rst_t4", gun_v, 31);
      tick();
      chk("after_rst_t5", gun_v, 30);
      joy_up = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
